stonyman_pixel_sequencer: RTL and testbench
===========================================

# stonyman_pixel_sequencer

Walks the Stonyman 112x112 image sensor through one frame in raster order. For each pixel it programs the sensor's row/column select registers over the RESP/INCP/RESV/INCV pulse interface, waits a settle time, then requests a sample from the downstream ADC controller. It waits for that controller's capture-done before moving on. It sits between the APB frame-control registers and the ADC controller, and drives the `adc_capture_start` / `adc_capture_done` handshake.

## Interface
- `ROWS`, 112, rows per frame (1..255)
- `COLS`, 112, columns per frame (1..255)
- `PULSE_CYCLES`, 2, high time and low time of every sensor pin pulse, in clk cycles (>=1)

- `clk`  in  1  system clock, 40 MHz
- `reset`  in  1  synchronous, active-high
- `frame_start`  in  1  one-cycle request; starts a frame when idle
- `frame_abort`  in  1  one-cycle; abandons the current frame
- `settle_counts`  in  8  settle cycles after pixel select; sampled at frame start
- `adc_capture_done`  in  1  one-cycle pulse from ADC controller: sample taken, sensor may move
- `adc_capture_start`  out  1  one-cycle capture request to ADC controller
- `resp`, `incp`, `resv`, `incv`  out  1 each  Stonyman pointer/value reset and increment pins
- `frame_busy`  out  1  high from the cycle after accepted start until DONE/abort
- `frame_done`  out  1  one-cycle pulse after the last pixel's capture-done
- `pixel_row`, `pixel_col`  out  8 each  coordinates of the pixel currently selected
- `seq_state`  out  4  state encoding, test point

## Operation
- Sensor registers: pointer 0 = COLSEL, pointer 1 = ROWSEL.
- A pulse is PULSE_CYCLES high then PULSE_CYCLES low. An N-pulse op takes 2·P·N cycles; N=0 takes 0 cycles.
- States, in order:
  - IDLE: no pins active; frame_start goes to ROW_PTR, with row=col=0 and settle latched as max(settle_counts,1).
  - ROW_PTR: 1 resp pulse, then 1 incp pulse.
  - ROW_VAL: 1 resv pulse, then `row` incv pulses.
  - COL_PTR: 1 resp pulse.
  - COL_VAL: 1 resv pulse.
  - SETTLE: S cycles, all pins low.
  - CAPTURE: adc_capture_start=1 for 1 cycle.
  - WAIT_DONE: hold until adc_capture_done.
  - NEXT: if col<COLS-1, col+1, 1 incv pulse, then SETTLE. Else if row<ROWS-1, row+1, col=0, then ROW_PTR. Else DONE.
  - DONE: frame_done=1 for 1 cycle, then IDLE.
- adc_capture_done is ignored outside WAIT_DONE, including the same cycle as adc_capture_start.
- frame_start while busy is ignored; it is not queued.
- frame_abort (any non-IDLE state) goes to IDLE next cycle: all pins low, frame_busy=0, no frame_done. Abort beats frame_start if both are asserted.
- At most one of resp/incp/resv/incv is high in any cycle.
- row/col counters are 8-bit and never exceed ROWS-1/COLS-1.

## Timing
- Reset values: all outputs 0, state IDLE, row=col=0.
- All outputs are registered.
- Cycle 0 is the frame_start sample cycle. From cycle 1: frame_busy=1 and resp=1.
- Row-r start latency: ROW_PTR..COL_VAL take 10P+2P·r cycles. The first adc_capture_start is at cycle 10P+S+1.
- Column advance: with done sampled in cycle d, incv is high in d+1..d+P and low in d+P+1..d+2P. adc_capture_start fires at d+2P+S+1. pixel_col updates at d+1.
- Row advance: with done in cycle d, the next adc_capture_start fires at d+10P+2P·(row+1)+S+1.
- frame_done: 1 cycle after the last done is sampled. frame_busy drops the same cycle.
- Reset mid-frame behaves as abort and also clears the counters.

## Test plan
- P=2, S=3, frame_start at cycle 0, done returned 5 cycles after each start -> resp high in cycles 1-2, incp high in 5-6, resv high in 9-10, resp high in 13-14, resv high in 17-18, adc_capture_start high in cycle 24 only.
- ROWS=2, COLS=3, auto-done -> exactly 6 adc_capture_start pulses with (row,col) sequence 00,01,02,10,11,12. Row-1 ROW_VAL shows exactly 1 incv pulse. Single frame_done, then IDLE.
- settle_counts=0 -> SETTLE lasts 1 cycle. settle_counts changed mid-frame -> per-pixel timing unchanged.
- adc_capture_done withheld 100 cycles -> sequencer holds in WAIT_DONE with pins low. Stray done pulses during SETTLE have no effect.
- frame_abort in the 3rd pixel's WAIT_DONE with simultaneous frame_start -> IDLE next cycle, busy=0, no frame_done. A later frame_start restarts at row 0, col 0.
- frame_start while busy and reset mid-pulse -> start ignored. Reset clears all pins the next cycle with no residual pulse.

Source files
------------

// File: rtl/stonyman_pixel_sequencer.sv
`default_nettype none
// stonyman_pixel_sequencer: walks the Stonyman sensor through one frame in raster order,
// selecting each pixel over RESP/INCP/RESV/INCV and handshaking one ADC capture per pixel.
module stonyman_pixel_sequencer #(
    parameter int ROWS         = 112,
    parameter int COLS         = 112,
    parameter int PULSE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       frame_abort,
    input  logic [7:0] settle_counts,
    input  logic       adc_capture_done,
    output logic       adc_capture_start,
    output logic       resp,
    output logic       incp,
    output logic       resv,
    output logic       incv,
    output logic       frame_busy,
    output logic       frame_done,
    output logic [7:0] pixel_row,
    output logic [7:0] pixel_col,
    output logic [3:0] seq_state
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ROW_PTR   = 4'd1;
    localparam logic [3:0] S_ROW_VAL   = 4'd2;
    localparam logic [3:0] S_COL_PTR   = 4'd3;
    localparam logic [3:0] S_COL_VAL   = 4'd4;
    localparam logic [3:0] S_SETTLE    = 4'd5;
    localparam logic [3:0] S_CAPTURE   = 4'd6;
    localparam logic [3:0] S_WAIT_DONE = 4'd7;
    localparam logic [3:0] S_NEXT      = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;

    localparam int              TICK_W    = $clog2(2 * PULSE_CYCLES) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(2 * PULSE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_HIGH = TICK_W'(PULSE_CYCLES);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [7:0]      ROW_LAST  = 8'(ROWS - 1);
    localparam logic [7:0]      COL_LAST  = 8'(COLS - 1);

    logic [3:0]        state, state_n;
    logic [TICK_W-1:0] tick, tick_n;
    logic [7:0]        pidx, pidx_n;
    logic [7:0]        scnt, scnt_n;
    logic [7:0]        settle, settle_n;
    logic [7:0]        row, row_n;
    logic [7:0]        col, col_n;
    logic [7:0]        op_last;
    logic              pulse_done;
    logic [3:0]        pins_n;    // {resp, incp, resv, incv}
    logic              cap_n, busy_n, done_n;

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            tick   <= '0;
            pidx   <= '0;
            scnt   <= '0;
            settle <= 8'd1;
            row    <= '0;
            col    <= '0;
            {resp, incp, resv, incv} <= 4'b0000;
            adc_capture_start <= 1'b0;
            frame_busy        <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            state  <= state_n;
            tick   <= tick_n;
            pidx   <= pidx_n;
            scnt   <= scnt_n;
            settle <= settle_n;
            row    <= row_n;
            col    <= col_n;
            {resp, incp, resv, incv} <= pins_n;
            adc_capture_start <= cap_n;
            frame_busy        <= busy_n;
            frame_done        <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_n     = tick;
        pidx_n     = pidx;
        scnt_n     = scnt;
        settle_n   = settle;
        row_n      = row;
        col_n      = col;
        pulse_done = 1'b0;
        op_last    = (state == S_ROW_PTR) ? 8'd1 : ((state == S_ROW_VAL) ? row : 8'd0);

        // Pulse trains: tick walks one high+low period, pidx counts pulses in the op.
        if (state inside {S_ROW_PTR, S_ROW_VAL, S_COL_PTR, S_COL_VAL, S_NEXT}) begin
            if (tick == TICK_LAST) begin
                tick_n = '0;
                if (pidx == op_last) begin
                    pidx_n     = '0;
                    pulse_done = 1'b1;
                end else begin
                    pidx_n = pidx + 8'd1;
                end
            end else begin
                tick_n = tick + TICK_ONE;
            end
        end

        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_n  = S_ROW_PTR;
                    tick_n   = '0;
                    pidx_n   = '0;
                    row_n    = '0;
                    col_n    = '0;
                    settle_n = (settle_counts == 8'd0) ? 8'd1 : settle_counts;
                end
            end
            S_ROW_PTR: if (pulse_done) state_n = S_ROW_VAL;
            S_ROW_VAL: if (pulse_done) state_n = S_COL_PTR;
            S_COL_PTR: if (pulse_done) state_n = S_COL_VAL;
            S_COL_VAL, S_NEXT: begin
                if (pulse_done) begin
                    state_n = S_SETTLE;
                    scnt_n  = '0;
                end
            end
            S_SETTLE: begin
                if (scnt == settle - 8'd1) state_n = S_CAPTURE;
                else                       scnt_n  = scnt + 8'd1;
            end
            S_CAPTURE: state_n = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (adc_capture_done) begin
                    tick_n = '0;
                    pidx_n = '0;
                    if (col < COL_LAST) begin
                        col_n   = col + 8'd1;
                        state_n = S_NEXT;
                    end else if (row < ROW_LAST) begin
                        row_n   = row + 8'd1;
                        col_n   = '0;
                        state_n = S_ROW_PTR;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (frame_abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
            tick_n  = '0;
            pidx_n  = '0;
            scnt_n  = '0;
        end
    end

    always_comb begin
        pins_n = 4'b0000;
        if (tick_n < TICK_HIGH) begin
            case (state_n)
                S_ROW_PTR: pins_n = (pidx_n == 8'd0) ? 4'b1000 : 4'b0100;
                S_ROW_VAL: pins_n = (pidx_n == 8'd0) ? 4'b0010 : 4'b0001;
                S_COL_PTR: pins_n = 4'b1000;
                S_COL_VAL: pins_n = 4'b0010;
                S_NEXT:    pins_n = 4'b0001;
                default:   pins_n = 4'b0000;
            endcase
        end
        cap_n  = (state_n == S_CAPTURE);
        busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n = (state_n == S_DONE);
    end

    assign pixel_row = row;
    assign pixel_col = col;
    assign seq_state = state;

endmodule
`default_nettype wire

// File: tb/tb_stonyman_pixel_sequencer.sv
`default_nettype none
// Bench for stonyman_pixel_sequencer: compares every cycle against a frame timeline
// built from the pixel-walk rules, with randomized done latency and stray inputs.
module tb_stonyman_pixel_sequencer;
    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int P    = 2;

    localparam logic [3:0] RESP = 4'b1000;
    localparam logic [3:0] INCP = 4'b0100;
    localparam logic [3:0] RESV = 4'b0010;
    localparam logic [3:0] INCV = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_abort = 1'b0;
    logic       adc_capture_done = 1'b0;
    logic [7:0] settle_counts = 8'd0;
    logic       adc_capture_start, resp, incp, resv, incv, frame_busy, frame_done;
    logic [7:0] pixel_row, pixel_col;
    logic [3:0] seq_state;
    logic [22:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline entry: {pins[22:19], cap[18], busy[17], done[16], row[15:8], col[7:0]}
    logic [22:0] exp_q[$];
    bit          done_q[$];
    bit          wait_q[$];
    logic [7:0]  last_row = 8'd0;
    logic [7:0]  last_col = 8'd0;

    stonyman_pixel_sequencer #(.ROWS(ROWS), .COLS(COLS), .PULSE_CYCLES(P)) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_start      (frame_start),
        .frame_abort      (frame_abort),
        .settle_counts    (settle_counts),
        .adc_capture_done (adc_capture_done),
        .adc_capture_start(adc_capture_start),
        .resp             (resp),
        .incp             (incp),
        .resv             (resv),
        .incv             (incv),
        .frame_busy       (frame_busy),
        .frame_done       (frame_done),
        .pixel_row        (pixel_row),
        .pixel_col        (pixel_col),
        .seq_state        (seq_state)
    );

    assign obs = {resp, incp, resv, incv, adc_capture_start, frame_busy, frame_done, pixel_row, pixel_col};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] pins, input bit cap, input bit busy, input bit fd,
                        input logic [7:0] r, input logic [7:0] c, input bit dn, input bit wt);
        exp_q.push_back({pins, cap, busy, fd, r, c});
        done_q.push_back(dn);
        wait_q.push_back(wt);
    endtask

    task automatic push_pulses(input logic [3:0] pins, input int n, input logic [7:0] r, input logic [7:0] c);
        for (int k = 0; k < n; k++)
            for (int t = 0; t < 2 * P; t++)
                push((t < P) ? pins : 4'b0000, 1'b0, 1'b1, 1'b0, r, c, 1'b0, 1'b0);
    endtask

    // Builds and plays one frame. long_pix gets a 100-cycle done latency; abort_pix
    // aborts (with a simultaneous start) in that pixel's first WAIT_DONE cycle.
    task automatic run_frame(input int s_in, input int first_delay, input int long_pix, input int abort_pix);
        int s, pix, abort_idx, caps, dones, first_cap, k;
        logic [7:0] rr, cc;
        s = (s_in == 0) ? 1 : s_in;
        exp_q.delete();
        done_q.delete();
        wait_q.delete();
        abort_idx = -1;
        pix = 0;
        push(4'b0000, 1'b0, 1'b0, 1'b0, last_row, last_col, 1'b0, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                rr = 8'(r);
                cc = 8'(c);
                if (c == 0) begin
                    push_pulses(RESP, 1, rr, cc);
                    push_pulses(INCP, 1, rr, cc);
                    push_pulses(RESV, 1, rr, cc);
                    push_pulses(INCV, r, rr, cc);
                    push_pulses(RESP, 1, rr, cc);
                    push_pulses(RESV, 1, rr, cc);
                end else begin
                    push_pulses(INCV, 1, rr, cc);
                end
                for (int t = 0; t < s; t++) push(4'b0000, 1'b0, 1'b1, 1'b0, rr, cc, 1'b0, 1'b0);
                push(4'b0000, 1'b1, 1'b1, 1'b0, rr, cc, 1'b0, 1'b0);
                if (pix == abort_pix) abort_idx = exp_q.size();
                k = (pix == 0) ? first_delay : ((pix == long_pix) ? 100 : int'($urandom_range(1, 6)));
                for (int w = 1; w <= k; w++) push(4'b0000, 1'b0, 1'b1, 1'b0, rr, cc, (w == k), 1'b1);
                pix++;
            end
        end
        push(4'b0000, 1'b0, 1'b0, 1'b1, 8'(ROWS - 1), 8'(COLS - 1), 1'b0, 1'b0);
        push(4'b0000, 1'b0, 1'b0, 1'b0, 8'(ROWS - 1), 8'(COLS - 1), 1'b0, 1'b0);
        if (abort_idx >= 0) begin
            while (exp_q.size() > abort_idx + 1) begin
                void'(exp_q.pop_back());
                void'(done_q.pop_back());
                void'(wait_q.pop_back());
            end
            done_q[abort_idx] = 1'b0;
            rr = exp_q[abort_idx][15:8];
            cc = exp_q[abort_idx][7:0];
            push(4'b0000, 1'b0, 1'b0, 1'b0, rr, cc, 1'b0, 1'b0);
        end
        last_row = exp_q[exp_q.size() - 1][15:8];
        last_col = exp_q[exp_q.size() - 1][7:0];

        caps = 0;
        dones = 0;
        first_cap = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("cyc%0d", i), 32'(obs), 32'(exp_q[i]));
            if (adc_capture_start) begin
                caps++;
                if (first_cap < 0) first_cap = i;
            end
            if (frame_done) dones++;
            frame_start = (i == 0) || (i == abort_idx) ||
                          ((exp_q[i][17] || exp_q[i][16]) && ($urandom_range(0, 7) == 0));
            frame_abort = (i == abort_idx);
            adc_capture_done = done_q[i] || (!wait_q[i] && ($urandom_range(0, 3) == 0));
            settle_counts = (i == 0) ? 8'(s_in) : 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
        frame_abort = 1'b0;
        adc_capture_done = 1'b0;
        check("captures", caps, (abort_idx >= 0) ? abort_pix + 1 : ROWS * COLS);
        check("frame_done_count", dones, (abort_idx >= 0) ? 0 : 1);
        check("first_capture_cycle", first_cap, 10 * P + s + 1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({obs, seq_state}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", 32'({obs, seq_state}), 32'd0);

        run_frame(3, 5, -1, -1);
        run_frame(0, 2, 4, -1);
        run_frame(3, 3, -1, 2);
        repeat (4) run_frame(int'($urandom_range(0, 6)), int'($urandom_range(1, 6)), -1, -1);

        // Reset landing in the middle of the first resp pulse, with a competing start.
        frame_start = 1'b1;
        @(posedge clk); #1;
        check("restart_resp", 32'(resp), 32'd1);
        frame_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        check("reset_midpulse", 32'({obs, seq_state}), 32'd0);
        reset = 1'b0;
        frame_start = 1'b0;
        @(posedge clk); #1;
        check("no_residual_pulse", 32'({obs, seq_state}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
